// File: rtl/alu_issue_ctrl.sv
// Issue controller for a single-cycle 64-bit ALU. It decodes the operation,
// holds operands for one execute cycle, and captures the result behind a valid/ready handshake.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  aluop,
    input  logic [10:0] opcode,
    input  logic [63:0] op_a,
    input  logic [63:0] op_b,
    output logic [63:0] alu_value1,
    output logic [63:0] alu_value2,
    output logic [3:0]  alu_ctrl,
    input  logic [63:0] alu_result,
    input  logic        alu_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic        out_zero,
    output logic        out_err,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {illegal, alu_ctrl}.
    function automatic logic [4:0] decode_op(input logic [1:0] op, input logic [10:0] opc);
        logic [4:0] r;
        r = {1'b1, 4'b0010};
        case (op)
            2'b00: r = {1'b0, 4'b0010};
            2'b01: r = {1'b0, 4'b0110};
            2'b10: begin
                case (opc)
                    11'b10001011000: r = {1'b0, 4'b0010};
                    11'b11001011000: r = {1'b0, 4'b0110};
                    11'b10001010000: r = {1'b0, 4'b0000};
                    11'b10101010000: r = {1'b0, 4'b0001};
                    default:         r = {1'b1, 4'b0010};
                endcase
            end
            default: r = {1'b1, 4'b0010};
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [63:0] a_q, a_d, b_q, b_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [63:0] res_q, res_d;
    logic        zero_q, zero_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  dec_s;
    logic        illegal_s;

    assign dec_s     = decode_op(aluop, opcode);
    assign illegal_s = dec_s[4];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = illegal_s ? DONE : EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: state_d = DONE;
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Datapath next values; an illegal request keeps the previous ALU control
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        ctrl_d = ctrl_q;
        res_d  = res_q;
        zero_d = zero_q;
        err_d  = err_q;
        cnt_d  = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d = op_a;
                    b_d = op_b;
                    if (illegal_s) begin
                        res_d  = 64'd0;
                        zero_d = 1'b0;
                        err_d  = 1'b1;
                    end else begin
                        ctrl_d = dec_s[3:0];
                    end
                end else begin
                    a_d = a_q;
                end
            end
            EXEC: begin
                res_d  = alu_result;
                zero_d = alu_zero;
                err_d  = 1'b0;
            end
            DONE: begin
                if (out_ready) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: cnt_d = cnt_q;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= 64'd0;
            b_q    <= 64'd0;
            ctrl_q <= 4'b0010;
            res_q  <= 64'd0;
            zero_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= 16'd0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            ctrl_q <= ctrl_d;
            res_q  <= res_d;
            zero_q <= zero_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign alu_value1 = a_q;
    assign alu_value2 = b_q;
    assign alu_ctrl   = ctrl_q;
    assign out_result = res_q;
    assign out_zero   = zero_q;
    assign out_err    = err_q;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU stub on the ALU-facing ports.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  aluop;
    logic [10:0] opcode;
    logic [63:0] op_a, op_b;
    logic [63:0] alu_value1, alu_value2;
    logic [3:0]  alu_ctrl;
    logic [63:0] alu_result;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        out_zero;
    logic        out_err;
    logic [15:0] op_count;

    typedef struct packed {
        logic        err;
        logic        zero;
        logic [63:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   seen = 1'b0;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .opcode(opcode), .op_a(op_a), .op_b(op_b),
        .alu_value1(alu_value1), .alu_value2(alu_value2), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_err(out_err), .op_count(op_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ALU stub
    always_comb begin
        case (alu_ctrl)
            4'b0010: alu_result = alu_value1 + alu_value2;
            4'b0110: alu_result = alu_value1 - alu_value2;
            4'b0000: alu_result = alu_value1 & alu_value2;
            4'b0001: alu_result = alu_value1 | alu_value2;
            default: alu_result = 64'd0;
        endcase
        alu_zero = (alu_result == 64'd0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares the first cycle of every out_valid pulse with the scoreboard head
    always @(negedge clk) begin
        if (out_valid && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got result %h with empty scoreboard", out_result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_result", out_result, e.res);
                chk("sb_zero", 64'(out_zero), 64'(e.zero));
                chk("sb_err", 64'(out_err), 64'(e.err));
            end
        end else if (!out_valid) begin
            seen = 1'b0;
        end
    end

    // Called at a negedge; returns at the negedge where out_valid first shows.
    task automatic issue(input logic [1:0] op, input logic [10:0] opc,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] er, input logic ez, input logic ee,
                         input logic [3:0] ec, input bit hold, output int acc_cyc);
        int w;
        aluop = op; opcode = opc; op_a = a; op_b = b; in_valid = 1'b1;
        exp_q.push_back('{err: ee, zero: ez, res: er});
        w = 0;
        acc_cyc = -1;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            if (!hold) in_valid = 1'b0;
            @(negedge clk);
            chk("alu_ctrl", 64'(alu_ctrl), 64'(ec));
            chk("alu_value1", alu_value1, a);
            chk("valid_edge_n", 64'(out_valid), 64'(ee));
            if (!ee) begin
                @(negedge clk);
                chk("valid_edge_n1", 64'(out_valid), 64'd1);
            end
        end
    endtask

    // Expects the handshake at the next edge and checks the count afterwards
    task automatic finish_op(input logic [15:0] exp_cnt);
        @(negedge clk);
        chk("valid_dropped", 64'(out_valid), 64'd0);
        chk("op_count", 64'(op_count), 64'(exp_cnt));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_result"}, out_result, 64'd0);
        chk({tag, "_out_zero"}, 64'(out_zero), 64'd0);
        chk({tag, "_out_err"}, 64'(out_err), 64'd0);
        chk({tag, "_op_count"}, 64'(op_count), 64'd0);
        chk({tag, "_alu_value1"}, alu_value1, 64'd0);
        chk({tag, "_alu_value2"}, alu_value2, 64'd0);
        chk({tag, "_alu_ctrl"}, 64'(alu_ctrl), 64'(4'b0010));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int rel, acc1, acc2;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        aluop = 2'b00; opcode = 11'd0; op_a = 64'd0; op_b = 64'd0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");

        // ADD right after reset release: accepted on the first edge
        rst = 1'b0;
        rel = cyc;
        issue(2'b10, 11'b10001011000, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0, 4'b0010, 1'b0, acc1);
        chk("first_accept", 64'(acc1 - rel), 64'd1);
        finish_op(16'd1);

        // SUB to zero with the consumer stalled for four cycles
        out_ready = 1'b0;
        issue(2'b01, 11'd0, 64'h1234, 64'h1234, 64'd0, 1'b1, 1'b0, 4'b0110, 1'b0, acc1);
        in_valid = 1'b1; aluop = 2'b00; op_a = 64'd99; op_b = 64'd1;
        for (int i = 0; i < 4; i++) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_result", out_result, 64'd0);
            chk("hold_zero", 64'(out_zero), 64'd1);
            chk("hold_value1", alu_value1, 64'h1234);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        finish_op(16'd2);

        // Illegal opcode under aluop 10, then aluop 11: control keeps 0110
        issue(2'b10, 11'b11111111111, 64'd3, 64'd4, 64'd0, 1'b0, 1'b1, 4'b0110, 1'b0, acc1);
        finish_op(16'd3);
        chk("err_kept_idle", 64'(out_err), 64'd1);
        issue(2'b11, 11'b10001011000, 64'd8, 64'd9, 64'd0, 1'b0, 1'b1, 4'b0110, 1'b0, acc1);
        finish_op(16'd4);

        // SUB via opcode, and a 64-bit add that wraps to zero
        issue(2'b10, 11'b11001011000, 64'd10, 64'd3, 64'd7, 1'b0, 1'b0, 4'b0110, 1'b0, acc1);
        finish_op(16'd5);
        issue(2'b00, 11'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 4'b0010, 1'b0, acc1);
        finish_op(16'd6);

        // Back-to-back AND then ORR with in_valid held high
        issue(2'b10, 11'b10001010000, 64'hF0, 64'h3C, 64'h30, 1'b0, 1'b0, 4'b0000, 1'b1, acc1);
        issue(2'b10, 11'b10101010000, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0, 4'b0001, 1'b0, acc2);
        chk("b2b_spacing", 64'(acc2 - acc1), 64'd3);
        finish_op(16'd8);
        chk("result_kept_idle", out_result, 64'hFF);

        // Reset pulse in the middle of EXEC
        aluop = 2'b01; op_a = 64'd50; op_b = 64'd8; in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_exec");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_exec_no_valid", 64'(out_valid), 64'd0);
        end
        chk("rst_exec_count", 64'(op_count), 64'd0);

        // Counter wrap
        force dut.cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.cnt_q;
        @(negedge clk);
        chk("preload_count", 64'(op_count), 64'hFFFF);
        issue(2'b11, 11'd0, 64'd1, 64'd2, 64'd0, 1'b0, 1'b1, 4'b0010, 1'b0, acc1);
        finish_op(16'h0000);

        repeat (2) @(negedge clk);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port list, SHALL be exactly:
  clk  in  1  rising-edge clock
  rst  in  1  asynchronous active-high reset
  in_valid  in  1  request offered
  in_ready  out  1  request accepted when high with in_valid
  aluop  in  2  main-control ALU operation class
  opcode  in  11  instruction opcode field [31:21]
  op_a  in  64  first operand
  op_b  in  64  second operand
  alu_value1  out  64  to ALU value1
  alu_value2  out  64  to ALU value2
  alu_ctrl  out  4  to ALU ALUControlInput
  alu_result  in  64  from ALU ALUResult (combinational)
  alu_zero  in  1  from ALU zero
  out_valid  out  1  result available
  out_ready  in  1  consumer accepts result
  out_result  out  64  captured result
  out_zero  out  1  captured zero flag
  out_err  out  1  illegal operation flag
  op_count  out  16  completed-output counter

Function
REQ-003 Decode SHALL be: aluop 00 -> 0010 (add); aluop 01 -> 0110 (subtract); aluop 11 -> illegal.
REQ-004 aluop 10 SHALL decode opcode: 10001011000 -> 0010; 11001011000 -> 0110; 10001010000 -> 0000; 10101010000 -> 0001; any other opcode -> illegal.
REQ-005 FSM SHALL have states IDLE, EXEC, DONE; reset state IDLE.
REQ-006 in_ready SHALL be 1 only in IDLE, combinationally from state.
REQ-007 IDLE, in_valid=1: at the edge, op_a/op_b/decoded ctrl SHALL be registered; legal -> EXEC, illegal -> DONE with out_err=1, out_result=0, out_zero=0.
REQ-008 IDLE, in_valid=0: SHALL remain IDLE, no register change.
REQ-009 alu_value1/alu_value2/alu_ctrl SHALL be driven from operand/ctrl registers in every state; they change only on acceptance.
REQ-010 EXEC SHALL last exactly one cycle; at its closing edge alu_result -> out_result, alu_zero -> out_zero, out_err=0, state -> DONE.
REQ-011 out_valid SHALL be 1 exactly in DONE; out_result/out_zero/out_err SHALL be stable while out_valid=1.
REQ-012 DONE with out_ready=1 SHALL return to IDLE at that edge and increment op_count; out_ready=0 SHALL hold DONE indefinitely.
REQ-013 Legal-op latency: acceptance edge N -> out_valid high after edge N+1; illegal-op: out_valid high after edge N.
REQ-014 Max throughput SHALL be one operation per 3 cycles (legal) / 2 cycles (illegal); no request accepted in EXEC or DONE.
REQ-015 op_count SHALL count both legal and illegal completions, modulo 2^16 (0xFFFF -> 0x0000).
REQ-016 out_result, out_zero, out_err SHALL keep their last value after returning to IDLE.
REQ-017 in_valid and out_ready SHALL be ignored in states where they have no effect (REQ-006, REQ-012).

Reset
REQ-018 rst=1 SHALL asynchronously force: state IDLE, in_ready=1, out_valid=0, out_result=0, out_zero=0, out_err=0, op_count=0, alu_value1=0, alu_value2=0, alu_ctrl=0010.
REQ-019 Reset asserted in EXEC or DONE SHALL abort the operation with no output handshake and no op_count increment.
REQ-020 First acceptance SHALL be possible at the first rising edge after rst deasserts.

Verification
REQ-021 ADD: aluop=10, opcode=10001011000, op_a=5, op_b=7, out_ready=1 -> alu_ctrl=0010, out_result=12, out_zero=0, out_err=0, out_valid one cycle, op_count=1.
REQ-022 SUB zero: aluop=01, op_a=op_b=0x1234 -> out_result=0, out_zero=1; out_ready held 0 for 4 cycles -> out_valid and values stable 4 cycles, in_ready=0 throughout.
REQ-023 Illegal: aluop=10, opcode=11111111111 -> out_valid after one edge, out_err=1, out_result=0; alu_ctrl unchanged from previous op; op_count increments.
REQ-024 Back-to-back: in_valid held 1 with AND (0xF0 & 0x3C) then ORR (0xF0 | 0x0F) -> results 0x30 then 0xFF, second accepted only after first out handshake, 3-cycle spacing.
REQ-025 Reset in EXEC: rst pulsed mid-EXEC -> out_valid never asserts, all outputs at REQ-018 values, op_count=0.
REQ-026 Wrap: preload 65535 completions (or force op_count=0xFFFF) then one op -> op_count=0x0000.
